mem_bus_bridge: RTL and testbench

//  Memory-side bridge directly upstream of the processor's instruction port.

---
 rtl/cpu_bus_pkg.sv | 15 +
 rtl/bus_timeout_ctr.sv | 29 ++
 rtl/mem_bus_bridge.sv | 157 +++++++++++++++
 tb/tb_mem_bus_bridge.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the processor-to-memory bridge.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic        RW_READ  = 1'b1;
  localparam logic        RW_WRITE = 1'b0;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts BUSY cycles; expired_c flags the cycle on which the count reaches TIMEOUT.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CW'(1);
    end
  end

  // High when this enabled cycle is the TIMEOUT-th one
  assign expired_c = en & (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_bridge.sv
// Converts one-cycle processor strobes into a req/ack memory handshake,
// stalling the core while an access is outstanding.
module mem_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW         = 16,
  parameter int unsigned TIMEOUT    = 15,
  parameter logic [31:0] RESET_WORD = NOP_WORD
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          proc_stb,
  input  logic          proc_rw,
  input  logic [31:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  input  logic          proc_halt,
  output logic [31:0]   instruction,
  output logic          proc_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic          bus_err,
  output logic          halted
);

  state_t        state_q, state_d;
  logic          rw_q, rw_d;
  logic          halt_seen_q, halt_seen_d;
  logic [31:0]   instr_d;
  logic          stall_d, req_d, we_d, err_d, halted_d;
  logic [AW-1:0] addr_d;
  logic [31:0]   wdata_d;

  logic busy_c, oor_c, halt_now_c, ctr_clr_c, expired_c;

  assign busy_c     = (state_q == ST_BUSY);
  assign oor_c      = ((proc_addr >> AW) != 32'd0);
  assign halt_now_c = halt_seen_q | proc_halt;
  assign ctr_clr_c  = ~busy_c | mem_ack | expired_c;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (ctr_clr_c),
    .en        (busy_c),
    .expired_c (expired_c)
  );

  // Next-state and next-output logic; all outputs are registered below
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    halt_seen_d = halt_seen_q;
    instr_d     = instruction;
    stall_d     = proc_stall;
    req_d       = mem_req;
    we_d        = mem_we;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    err_d       = bus_err;
    halted_d    = halted;

    case (state_q)
      ST_IDLE: begin
        if (proc_halt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          req_d    = 1'b0;
          stall_d  = 1'b0;
        end else if (proc_stb) begin
          rw_d    = proc_rw;
          stall_d = 1'b1;
          if (oor_c) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            if (proc_rw == RW_READ) instr_d = RESET_WORD;
          end else begin
            state_d     = ST_BUSY;
            req_d       = 1'b1;
            we_d        = (proc_rw == RW_WRITE);
            addr_d      = proc_addr[AW-1:0];
            wdata_d     = proc_wdata;
            halt_seen_d = 1'b0;
          end
        end
      end

      ST_BUSY: begin
        halt_seen_d = halt_now_c;
        if (mem_ack || expired_c) begin
          req_d   = 1'b0;
          stall_d = 1'b0;
          // A late ack on the timeout cycle still completes normally
          if (mem_ack) begin
            if (rw_q == RW_READ) instr_d = mem_rdata;
          end else begin
            err_d = 1'b1;
            if (rw_q == RW_READ) instr_d = RESET_WORD;
          end
          if (halt_now_c) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_ERR: begin
        state_d = ST_IDLE;
        stall_d = 1'b0;
      end

      ST_HALT: begin
        halted_d = 1'b1;
        req_d    = 1'b0;
        stall_d  = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      halt_seen_q <= 1'b0;
      instruction <= RESET_WORD;
      proc_stall  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      bus_err     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      halt_seen_q <= halt_seen_d;
      instruction <= instr_d;
      proc_stall  <= stall_d;
      mem_req     <= req_d;
      mem_we      <= we_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      bus_err     <= err_d;
      halted      <= halted_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Table-driven scoreboard bench for mem_bus_bridge plus halt/reset corner sequences.
module tb_mem_bus_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned TO = 15;
  localparam int NV = 11;

  logic          clk;
  logic          reset_n;
  logic          proc_stb;
  logic          proc_rw;
  logic [31:0]   proc_addr;
  logic [31:0]   proc_wdata;
  logic          proc_halt;
  logic [31:0]   instruction;
  logic          proc_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          bus_err;
  logic          halted;

  mem_bus_bridge #(
    .AW         (AW),
    .TIMEOUT    (TO),
    .RESET_WORD (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .proc_stb    (proc_stb),
    .proc_rw     (proc_rw),
    .proc_addr   (proc_addr),
    .proc_wdata  (proc_wdata),
    .proc_halt   (proc_halt),
    .instruction (instruction),
    .proc_stall  (proc_stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .bus_err     (bus_err),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    int          ack_at;     // BUSY cycle on which ack is given, 0 = never
    logic [31:0] rdata;
    logic        oor;
    logic [31:0] exp_instr;
    logic        exp_err;
    int          exp_cycles; // cycles proc_stall stays high
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset_n   = 1'b0;
    proc_stb  = 1'b0;
    proc_halt = 1'b0;
    mem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Drive one access, service the memory side and check against the scoreboard
  task automatic access(input vec_t v);
    exp_t e;
    int cyc;
    proc_stb   = 1'b1;
    proc_rw    = v.rw;
    proc_addr  = v.addr;
    proc_wdata = v.wdata;
    sb.push_back('{instr: v.exp_instr, err: v.exp_err});
    step();
    proc_stb = 1'b0;
    chk("req_after_stb", 32'(mem_req), 32'(!v.oor));
    chk("stall_after_stb", 32'(proc_stall), 32'd1);
    if (!v.oor) begin
      chk("mem_addr", 32'(mem_addr), 32'(v.addr[AW-1:0]));
      chk("mem_we", 32'(mem_we), 32'(!v.rw));
      if (!v.rw) chk("mem_wdata", mem_wdata, v.wdata);
    end
    cyc = 0;
    while (proc_stall && cyc < 40) begin
      cyc++;
      if (cyc == v.ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
      end
      chk("req_during_busy", 32'(mem_req), 32'(!v.oor));
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'hX5X5_X5X5;
    end
    chk("stall_cycles", 32'(cyc), 32'(v.exp_cycles));
    chk("req_after_done", 32'(mem_req), 32'd0);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      chk("instruction", instruction, e.instr);
      chk("bus_err", 32'(bus_err), 32'(e.err));
    end
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0004, 1'b1, 32'h0,        1,  32'h2980_06E3, 1'b0, 32'h2980_06E3, 1'b0, 1};
    vecs[1]  = '{32'h0000_0020, 1'b1, 32'h0,        3,  32'h0000_0029, 1'b0, 32'h0000_0029, 1'b0, 3};
    vecs[2]  = '{32'h0000_0010, 1'b0, 32'h0000_070C, 1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0029, 1'b0, 1};
    vecs[3]  = '{32'h0000_0030, 1'b1, 32'h0,        15, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 15};
    vecs[4]  = '{32'h0000_FFFF, 1'b0, 32'h0000_1234, 2, 32'h1111_1111, 1'b0, 32'hCAFE_F00D, 1'b0, 2};
    vecs[5]  = '{32'h0000_0040, 1'b0, 32'h0000_0005, 0, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b1, 15};
    vecs[6]  = '{32'h0000_0050, 1'b1, 32'h0,        0,  32'h0,         1'b0, 32'h0000_0000, 1'b1, 15};
    vecs[7]  = '{32'h0000_0044, 1'b1, 32'h0,        1,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1, 1};
    vecs[8]  = '{32'h0001_0000, 1'b1, 32'h0,        0,  32'h0,         1'b1, 32'h0000_0000, 1'b1, 1};
    vecs[9]  = '{32'h8001_0004, 1'b0, 32'h0000_0009, 0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 1};
    vecs[10] = '{32'h0000_0060, 1'b1, 32'h0,        2,  32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, 1'b1, 2};

    reset_n    = 1'b1;
    proc_stb   = 1'b0;
    proc_rw    = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    proc_halt  = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    #2 reset_n = 1'b0;
    #4;
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_stall", 32'(proc_stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Ack while idle must be ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_instr", instruction, 32'h0);
    chk("idle_ack_stall", 32'(proc_stall), 32'd0);

    for (int i = 0; i < NV; i++) access(vecs[i]);

    // Halt raised mid-BUSY: access completes, then terminal halt
    proc_stb  = 1'b1;
    proc_rw   = 1'b1;
    proc_addr = 32'h0000_0008;
    step();
    proc_stb  = 1'b0;
    proc_halt = 1'b1;
    step();
    proc_halt = 1'b0;
    chk("halt_busy_req", 32'(mem_req), 32'd1);
    chk("halt_busy_halted", 32'(halted), 32'd0);
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    step();
    mem_ack = 1'b0;
    chk("halt_done_instr", instruction, 32'hA5A5_A5A5);
    chk("halt_done_halted", 32'(halted), 32'd1);
    chk("halt_done_stall", 32'(proc_stall), 32'd0);
    chk("halt_done_req", 32'(mem_req), 32'd0);
    proc_stb  = 1'b1;
    proc_addr = 32'h0000_000C;
    step();
    proc_stb = 1'b0;
    chk("halted_stb_req", 32'(mem_req), 32'd0);
    chk("halted_stb_stall", 32'(proc_stall), 32'd0);
    step();
    chk("halted_stb_req2", 32'(mem_req), 32'd0);
    chk("halted_stays", 32'(halted), 32'd1);

    // Halt and strobe in the same idle cycle: halt wins
    do_reset();
    chk("post_reset_halted", 32'(halted), 32'd0);
    proc_stb  = 1'b1;
    proc_halt = 1'b1;
    proc_rw   = 1'b1;
    proc_addr = 32'h0000_0004;
    step();
    proc_stb  = 1'b0;
    proc_halt = 1'b0;
    chk("halt_stb_req", 32'(mem_req), 32'd0);
    chk("halt_stb_halted", 32'(halted), 32'd1);
    chk("halt_stb_stall", 32'(proc_stall), 32'd0);

    // Asynchronous reset in the middle of a BUSY access
    do_reset();
    access(vecs[0]);
    proc_stb  = 1'b1;
    proc_rw   = 1'b1;
    proc_addr = 32'h0000_0070;
    step();
    proc_stb = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_stall", 32'(proc_stall), 32'd0);
    chk("async_rst_instr", instruction, 32'h0);
    step();
    reset_n = 1'b1;
    access(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
